// File: rtl/lns_pkg.sv
// Shared LNS definitions.
//   - Default operand geometry (integer/fraction bits of the log2 magnitude).
//   - Field positions of the packed LNS word {sign, zero, I, F}, MSB-first.
//   - Packed LNS operand type, shared by the fused multiply-add and the encoder.
//   - Decoder FSM state type.
package lns_pkg;

  localparam int LNS_INT_W  = 5;
  localparam int LNS_FRAC_W = 8;
  localparam int LNS_W      = 2 + LNS_INT_W + LNS_FRAC_W;
  localparam int SIGN_POS   = LNS_W - 1;
  localparam int ZERO_POS   = LNS_W - 2;

  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic signed [LNS_INT_W-1:0] i;
    logic [LNS_FRAC_W-1:0]       f;
  } lns_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUTPUT
  } dec_state_e;

endpackage

// File: rtl/lns_to_fixed_decoder_if.sv
// Handshake bundle of the LNS-to-fixed decoder.
//   in_valid/in_ready/lns_in     : operand side, lns_in = {sign, zero, I, F}
//   out_valid/out_ready/fx_out/ovf : result side, ovf qualified by out_valid
// master = producer/consumer around the decoder, slave = the decoder itself.
interface lns_to_fixed_decoder_if #(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16
);

  logic                      in_valid;
  logic                      in_ready;
  logic [2+INT_W+FRAC_W-1:0] lns_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          fx_out;
  logic                      ovf;

  modport master (
    output in_valid, lns_in, out_ready,
    input  in_ready, out_valid, fx_out, ovf
  );

  modport slave (
    input  in_valid, lns_in, out_ready,
    output in_ready, out_valid, fx_out, ovf
  );

endinterface

// File: rtl/lns_dec_sign_sat.sv
// Final decode stage: turns the shifted magnitude into the signed result.
//   acc  : unsigned magnitude after the antilog shift
//   sign : operand sign, zero : operand is exactly zero
//   sat  : a set bit would have left the positive range during left shifts
//   rbit : last bit shifted out on right shifts (only with LNS_DEC_ROUND_EN)
//   fx   : signed result, ovf : result was saturated
// Saturation is symmetric: the most negative code is never produced.
module lns_dec_sign_sat #(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0] acc,
  input  logic             sign,
  input  logic             zero,
  input  logic             sat,
`ifdef LNS_DEC_ROUND_EN
  input  logic             rbit,
`endif
  output logic [OUT_W-1:0] fx,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

  logic [OUT_W-1:0] mag;

`ifdef LNS_DEC_ROUND_EN
  // Round half-up on the last discarded bit; magnitude is far below 2^(OUT_W-1).
  assign mag = acc + OUT_W'(rbit);
`else
  assign mag = acc;
`endif

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    fx  = '0;
    ovf = 1'b0;
    if (zero) begin
      fx = '0;
    end else if (sat) begin
      fx  = sign ? (~MAX_POS + 1'b1) : MAX_POS;
      ovf = 1'b1;
    end else begin
      fx = sign ? (~mag + 1'b1) : mag;
    end
  end

endmodule

// File: rtl/lns_to_fixed_decoder.sv
// LNS -> two's-complement fixed-point decoder (Mitchell antilog).
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset, discards any in-flight operand
//   bus   : slave side of lns_to_fixed_decoder_if (valid/ready in and out)
// 2^(I+F) is approximated as (1.F) * 2^I. {1,F} is shifted one bit per cycle
// by s = I + OUT_FRAC - FRAC_W positions, so latency is |s|+1 cycles.
// Requires FRAC_W+1 <= OUT_W-1. Optional build macro: LNS_DEC_ROUND_EN
// (round half-up on right shifts instead of truncating toward zero).
module lns_to_fixed_decoder
  import lns_pkg::*;
#(
  parameter int INT_W    = LNS_INT_W,
  parameter int FRAC_W   = LNS_FRAC_W,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  lns_to_fixed_decoder_if.slave  bus
);

  localparam int LW  = 2 + INT_W + FRAC_W;
  localparam int S_W = INT_W + 2;

  dec_state_e state, next_state;

  logic [OUT_W-1:0] acc;
  logic [S_W-1:0]   cnt;
  logic             right;
  logic             sign_q;
  logic             zero_q;
  logic             sat;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] fx_q;
  logic             ovf_q;
  logic [OUT_W-1:0] dec_fx;
  logic             dec_ovf;
`ifdef LNS_DEC_ROUND_EN
  logic             rbit;
`endif

  // Operand fields and shift distance.
  logic                    lns_sign;
  logic                    lns_zero;
  logic signed [INT_W-1:0] lns_i;
  logic [FRAC_W-1:0]       lns_f;
  logic signed [S_W-1:0]   s_val;
  logic [S_W-1:0]          s_mag;
  logic                    accept;

  assign lns_sign = bus.lns_in[LW-1];
  assign lns_zero = bus.lns_in[LW-2];
  assign lns_i    = bus.lns_in[INT_W+FRAC_W-1:FRAC_W];
  assign lns_f    = bus.lns_in[FRAC_W-1:0];
  assign s_val    = S_W'(lns_i) + S_W'(OUT_FRAC - FRAC_W);
  assign s_mag    = s_val[S_W-1] ? S_W'(-s_val) : s_val;
  assign accept   = bus.in_valid & in_ready_q & (state == IDLE);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fx_out    = fx_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (accept) next_state = (lns_zero || s_mag == '0) ? OUTPUT : SHIFT;
      SHIFT:  if (cnt == S_W'(1)) next_state = OUTPUT;
      OUTPUT: if (out_valid_q && bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc         <= '0;
      cnt         <= '0;
      right       <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      sat         <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fx_q        <= '0;
      ovf_q       <= 1'b0;
`ifdef LNS_DEC_ROUND_EN
      rbit        <= 1'b0;
`endif
    end else begin
      // Registered ready: low in reset, back high the cycle after a result leaves.
      in_ready_q <= (next_state == IDLE);
      unique case (state)
        IDLE: if (accept) begin
          sign_q <= lns_sign;
          zero_q <= lns_zero;
          acc    <= OUT_W'({1'b1, lns_f});
          cnt    <= s_mag;
          right  <= s_val[S_W-1];
          sat    <= 1'b0;
`ifdef LNS_DEC_ROUND_EN
          rbit   <= 1'b0;
`endif
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (right) begin
            acc <= acc >> 1;
`ifdef LNS_DEC_ROUND_EN
            rbit <= acc[0];
`endif
          end else begin
            // A one about to enter the sign bit means the value is out of range.
            if (acc[OUT_W-2]) sat <= 1'b1;
            acc <= acc << 1;
          end
        end
        OUTPUT: begin
          // First OUTPUT cycle captures the result; afterwards hold until taken.
          if (!out_valid_q) begin
            fx_q        <= dec_fx;
            ovf_q       <= dec_ovf;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  lns_dec_sign_sat #(.OUT_W(OUT_W)) u_sign_sat (
    .acc  (acc),
    .sign (sign_q),
    .zero (zero_q),
    .sat  (sat),
`ifdef LNS_DEC_ROUND_EN
    .rbit (rbit),
`endif
    .fx   (dec_fx),
    .ovf  (dec_ovf)
  );

endmodule

// File: tb/tb_lns_to_fixed_decoder.sv
// Directed, table-driven bench for lns_to_fixed_decoder (default geometry
// INT_W=5, FRAC_W=8, OUT_W=16, OUT_FRAC=8). Expected values are hand-derived
// from (1.F)*2^I scaled to 8 output fraction bits.
module tb_lns_to_fixed_decoder;
  import lns_pkg::*;

`ifdef LNS_DEC_ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  typedef struct {
    logic        sign;
    logic        zero;
    logic [4:0]  i;
    logic [7:0]  f;
    logic [15:0] exp_fx;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lns_to_fixed_decoder_if #(.INT_W(5), .FRAC_W(8), .OUT_W(16)) bus ();

  lns_to_fixed_decoder #(
    .INT_W(5), .FRAC_W(8), .OUT_W(16), .OUT_FRAC(8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for in_ready, present one operand for one accept edge.
  task automatic send(input logic sign, input logic zero, input logic [4:0] i, input logic [7:0] f);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.lns_in   = {sign, zero, i, f};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   lat;
    logic [15:0] held_fx;

    vecs = '{
      '{1'b0, 1'b0, 5'h00, 8'h00, 16'h0100, 1'b0, 1},   // 1.0
      '{1'b0, 1'b0, 5'h03, 8'h80, 16'h0C00, 1'b0, 4},   // 12.0
      '{1'b1, 1'b0, 5'h03, 8'h80, 16'hF400, 1'b0, 4},   // -12.0
      '{1'b1, 1'b0, 5'h1E, 8'h00, 16'hFFC0, 1'b0, 3},   // -0.25
      '{1'b0, 1'b0, 5'h07, 8'hFF, 16'h7FFF, 1'b1, 8},   // +sat
      '{1'b1, 1'b0, 5'h07, 8'hFF, 16'h8001, 1'b1, 8},   // -sat, symmetric
      '{1'b1, 1'b1, 5'h05, 8'h3C, 16'h0000, 1'b0, 1},   // zero flag wins
      '{1'b0, 1'b1, 5'h17, 8'h00, 16'h0000, 1'b0, 1},   // zero, I=-9
      '{1'b0, 1'b0, 5'h17, 8'h00, {15'd0, ROUND}, 1'b0, 10}, // underflow
      '{1'b0, 1'b0, 5'h1F, 8'h80, 16'h00C0, 1'b0, 2},   // 0.75
      '{1'b0, 1'b0, 5'h1F, 8'h81, {15'h0060, ROUND}, 1'b0, 2}, // 0.75+lsb/2
      '{1'b0, 1'b0, 5'h06, 8'hFF, 16'h7FC0, 1'b0, 7},   // largest unsaturated
      '{1'b1, 1'b0, 5'h10, 8'h00, 16'h0000, 1'b0, 17},  // I=-16, negative zero
      '{1'b0, 1'b0, 5'h0F, 8'h00, 16'h7FFF, 1'b1, 16}   // I=15, far overflow
    };

    bus.in_valid  = 1'b0;
    bus.lns_in    = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_fx_out",    {16'd0, bus.fx_out},    32'd0);
    check("rst_ovf",       {31'd0, bus.ovf},       32'd0);
    n_rst = 1'b1;

    // Table-driven vectors.
    for (int k = 0; k < 14; k++) begin
      send(vecs[k].sign, vecs[k].zero, vecs[k].i, vecs[k].f);
      wait_result(lat);
      check($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
      check($sformatf("v%0d_fx_out", k), {16'd0, bus.fx_out}, {16'd0, vecs[k].exp_fx});
      check($sformatf("v%0d_ovf", k), {31'd0, bus.ovf}, {31'd0, vecs[k].exp_ovf});
      take_result();
    end

    // Backpressure: result held 5 cycles, a pending operand must not be taken.
    send(1'b0, 1'b0, 5'h03, 8'h80);
    wait_result(lat);
    check("bp_latency", lat, 4);
    held_fx = bus.fx_out;
    check("bp_fx_first", {16'd0, held_fx}, 32'h0C00);
    bus.in_valid = 1'b1;
    bus.lns_in   = {1'b1, 1'b0, 5'h00, 8'h00};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c),    {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp_fx_c%0d", c),       {16'd0, bus.fx_out},    32'h0C00);
      check($sformatf("bp_ovf_c%0d", c),      {31'd0, bus.ovf},       32'd0);
      check($sformatf("bp_in_ready_c%0d", c), {31'd0, bus.in_ready},  32'd0);
    end
    bus.in_valid = 1'b0;
    take_result();
    @(negedge clk);
    check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("bp_valid_after",    {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-SHIFT: outputs clear at once, operand is discarded.
    send(1'b0, 1'b0, 5'h07, 8'hFF);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_fx_out",    {16'd0, bus.fx_out},    32'd0);
    check("mid_rst_ovf",       {31'd0, bus.ovf},       32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) check("post_rst_stale_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // Next operand after reset decodes normally.
    send(1'b1, 1'b0, 5'h1E, 8'h00);
    wait_result(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_fx_out", {16'd0, bus.fx_out}, 32'hFFC0);
    check("post_rst_ovf",    {31'd0, bus.ovf},    32'd0);
    take_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
